spi_loader: RTL and testbench

SPI_LOADER -- requirements
Module: spi_loader

---
 rtl/spi_loader.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_spi_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_loader.sv
// ---------------------------------------------------------------------------
// spi_loader
//   Receives file downloads from an IO controller over a slave SPI link and
//   turns them into a byte-wide write stream (ioctlAddr / ioctlData / ioctlWr).
//
//   Frame protocol, with spiS2 low for the whole frame:
//     0x55, idx  : select file index (ignored while a download is running)
//     0x53, 0xFF : start download, address restarts at 0
//     0x53, 0x00 : end download
//     0x54, d... : data bytes, one write per byte while downloading
//     other      : the rest of the frame is ignored
//
// Ports
//   clock         : system clock (at least 4x spiCk)
//   resetN        : asynchronous active-low reset
//   spiCk         : SPI clock, asynchronous, data sampled on its rising edge
//   spiS2         : active-low frame select, asynchronous
//   spiDi         : SPI data, MSB first
//   ioctlDownload : a download is in progress
//   ioctlIndex    : file index of the current / last download
//   ioctlAddr     : byte address of ioctlData (wraps silently)
//   ioctlData     : downloaded byte
//   ioctlWr       : one-cycle write strobe
// ---------------------------------------------------------------------------
module spi_loader #(
    parameter int AW = 24
) (
    input  logic          clock,
    input  logic          resetN,
    input  logic          spiCk,
    input  logic          spiS2,
    input  logic          spiDi,
    output logic          ioctlDownload,
    output logic [7:0]    ioctlIndex,
    output logic [AW-1:0] ioctlAddr,
    output logic [7:0]    ioctlData,
    output logic          ioctlWr
);

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_PARAM = 3'd2,
        ST_DATA  = 3'd3,
        ST_SKIP  = 3'd4
    } state_t;

    // Synchronisers and edge-detect history
    logic [2:0]    ck_sync_q,  ck_sync_d;
    logic [2:0]    s2_sync_q,  s2_sync_d;
    logic [2:0]    di_sync_q,  di_sync_d;
    logic [2:0]    sync_vld_q, sync_vld_d;
    logic          ck_last_q,  ck_last_d;
    logic          s2_last_q,  s2_last_d;
    logic          ck_rise_s;
    logic          s2_high_s;
    logic          s2_fall_s;

    // Byte assembly
    logic [2:0]    bit_cnt_q,    bit_cnt_d;
    logic [6:0]    shift_q,      shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    byte_q,       byte_d;

    // FSM
    state_t        state_q, state_d;
    logic          cmd_load_s;
    logic          dl_start_s;
    logic          dl_end_s;
    logic          idx_load_s;
    logic          wr_req_s;

    // Loader outputs and decoded command
    logic [7:0]    cmd_q,  cmd_d;
    logic          dl_q,   dl_d;
    logic [7:0]    idx_q,  idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q,   wr_d;

    // Synchroniser shift, edge detection and bit assembly next-state logic
    always_comb begin
        ck_sync_d  = {ck_sync_q[1:0], spiCk};
        s2_sync_d  = {s2_sync_q[1:0], spiS2};
        di_sync_d  = {di_sync_q[1:0], spiDi};
        // sync_vld marks which synchroniser stages hold a sampled value
        // rather than their reset value.
        sync_vld_d = {sync_vld_q[1:0], 1'b1};
        ck_last_d  = ck_sync_q[2];
        // Only a genuinely observed high level may arm the falling-edge
        // detector, so a select already low at reset release never opens a
        // frame in the middle of a transfer.
        if (sync_vld_q[2]) begin
            s2_last_d = s2_sync_q[2];
        end else begin
            s2_last_d = 1'b0;
        end

        ck_rise_s = ck_sync_q[2] & ~ck_last_q;
        s2_high_s = s2_sync_q[2];
        s2_fall_s = s2_last_q & ~s2_sync_q[2];

        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        if (s2_high_s) begin
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
        end else if (ck_rise_s) begin
            shift_d   = {shift_q[5:0], di_sync_q[2]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = {shift_q, di_sync_q[2]};
            end else begin
                byte_valid_d = 1'b0;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Front-end registers: synchronisers, edge history and byte assembly
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ck_sync_q    <= 3'b000;
            s2_sync_q    <= 3'b111;
            di_sync_q    <= 3'b000;
            sync_vld_q   <= 3'b000;
            ck_last_q    <= 1'b0;
            s2_last_q    <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'd0;
        end else begin
            ck_sync_q    <= ck_sync_d;
            s2_sync_q    <= s2_sync_d;
            di_sync_q    <= di_sync_d;
            sync_vld_q   <= sync_vld_d;
            ck_last_q    <= ck_last_d;
            s2_last_q    <= s2_last_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a released select always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (s2_high_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s2_fall_s) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (byte_valid_q) begin
                        case (byte_q)
                            CMD_FILE_TX:     state_d = ST_PARAM;
                            CMD_FILE_INDEX:  state_d = ST_PARAM;
                            CMD_FILE_TX_DAT: state_d = ST_DATA;
                            default:         state_d = ST_SKIP;
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_PARAM: begin
                    if (byte_valid_q) begin
                        state_d = ST_SKIP;
                    end else begin
                        state_d = ST_PARAM;
                    end
                end
                ST_DATA: state_d = ST_DATA;
                ST_SKIP: state_d = ST_SKIP;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: one-cycle action strobes derived from the current byte
    always_comb begin
        cmd_load_s = 1'b0;
        dl_start_s = 1'b0;
        dl_end_s   = 1'b0;
        idx_load_s = 1'b0;
        wr_req_s   = 1'b0;
        case (state_q)
            ST_CMD: cmd_load_s = byte_valid_q;
            ST_PARAM: begin
                if (byte_valid_q && (cmd_q == CMD_FILE_TX)) begin
                    dl_start_s = (byte_q == 8'hFF);
                    dl_end_s   = (byte_q == 8'h00);
                end else if (byte_valid_q && (cmd_q == CMD_FILE_INDEX)) begin
                    idx_load_s = ~dl_q;
                end else begin
                    idx_load_s = 1'b0;
                end
            end
            ST_DATA: wr_req_s = byte_valid_q & dl_q;
            default: cmd_load_s = 1'b0;
        endcase
    end

    // Loader register next-state: download flag, index, address and data
    always_comb begin
        cmd_d  = cmd_q;
        dl_d   = dl_q;
        idx_d  = idx_q;
        addr_d = addr_q;
        data_d = data_q;
        wr_d   = wr_req_s;

        if (cmd_load_s) begin
            cmd_d = byte_q;
        end else begin
            cmd_d = cmd_q;
        end

        if (dl_start_s) begin
            dl_d = 1'b1;
        end else if (dl_end_s) begin
            dl_d = 1'b0;
        end else begin
            dl_d = dl_q;
        end

        if (idx_load_s) begin
            idx_d = byte_q;
        end else begin
            idx_d = idx_q;
        end

        // The address is held through the strobe and advances right after it;
        // natural AW-bit overflow gives the silent wrap.
        if (dl_start_s) begin
            addr_d = {AW{1'b0}};
        end else if (wr_q) begin
            addr_d = addr_q + AW'(1);
        end else begin
            addr_d = addr_q;
        end

        if (wr_req_s) begin
            data_d = byte_q;
        end else begin
            data_d = data_q;
        end
    end

    // Loader registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cmd_q  <= 8'd0;
            dl_q   <= 1'b0;
            idx_q  <= 8'd0;
            addr_q <= {AW{1'b0}};
            data_q <= 8'd0;
            wr_q   <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            dl_q   <= dl_d;
            idx_q  <= idx_d;
            addr_q <= addr_d;
            data_q <= data_d;
            wr_q   <= wr_d;
        end
    end

    assign ioctlDownload = dl_q;
    assign ioctlIndex    = idx_q;
    assign ioctlAddr     = addr_q;
    assign ioctlData     = data_q;
    assign ioctlWr       = wr_q;

endmodule

// File: tb/tb_spi_loader.sv
module tb_spi_loader;

    localparam int AW = 4;
    // Input edge to visible strobe: 3 synchroniser stages + 2 clocks.
    localparam int EXP_LAT = 5;

    logic          clock;
    logic          resetN;
    logic          spiCk;
    logic          spiS2;
    logic          spiDi;
    logic          ioctlDownload;
    logic [7:0]    ioctlIndex;
    logic [AW-1:0] ioctlAddr;
    logic [7:0]    ioctlData;
    logic          ioctlWr;

    spi_loader #(.AW(AW)) dut (
        .clock         (clock),
        .resetN        (resetN),
        .spiCk         (spiCk),
        .spiS2         (spiS2),
        .spiDi         (spiDi),
        .ioctlDownload (ioctlDownload),
        .ioctlIndex    (ioctlIndex),
        .ioctlAddr     (ioctlAddr),
        .ioctlData     (ioctlData),
        .ioctlWr       (ioctlWr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    int cycle_cnt = 0;
    int rise_cyc  = 0;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Observed write strobes
    int  obs_addr[$];
    int  obs_data[$];
    int  obs_lat[$];
    int  wide_cnt = 0;
    logic wr_prev = 1'b0;
    always @(negedge clock) begin
        if (ioctlWr === 1'b1) begin
            obs_addr.push_back(int'(ioctlAddr));
            obs_data.push_back(int'(ioctlData));
            obs_lat.push_back(cycle_cnt - rise_cyc);
            if (wr_prev === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        wr_prev <= ioctlWr;
    end

    // Reference model: frame-level behaviour
    int  m_dl   = 0;
    int  m_idx  = 0;
    int  m_addr = 0;
    int  m_data = 0;
    int  exp_addr[$];
    int  exp_data[$];
    logic [7:0] tx_q[$];

    task automatic model_reset();
        m_dl = 0; m_idx = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_frame();
        if (tx_q.size() >= 1) begin
            case (tx_q[0])
                8'h53: if (tx_q.size() >= 2) begin
                    if (tx_q[1] == 8'hFF) begin m_dl = 1; m_addr = 0; end
                    else if (tx_q[1] == 8'h00) m_dl = 0;
                end
                8'h55: if (tx_q.size() >= 2 && m_dl == 0) m_idx = int'(tx_q[1]);
                8'h54: for (int i = 1; i < tx_q.size(); i++) begin
                    if (m_dl == 1) begin
                        exp_addr.push_back(m_addr);
                        exp_data.push_back(int'(tx_q[i]));
                        m_data = int'(tx_q[i]);
                        m_addr = (m_addr + 1) % (1 << AW);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".download"}, int'(ioctlDownload), m_dl);
        chk({tag, ".index"},    int'(ioctlIndex),    m_idx);
        chk({tag, ".addr"},     int'(ioctlAddr),     m_addr);
        chk({tag, ".data"},     int'(ioctlData),     m_data);
        chk({tag, ".wr_idle"},  int'(ioctlWr),       0);
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, ".wr_count"}, obs_addr.size(), exp_addr.size());
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.wr%0d_addr", tag, i), obs_addr[i], exp_addr[i]);
            chk($sformatf("%s.wr%0d_data", tag, i), obs_data[i], exp_data[i]);
            chk($sformatf("%s.wr%0d_lat",  tag, i), obs_lat[i],  EXP_LAT);
        end
        obs_addr.delete(); obs_data.delete(); obs_lat.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic spi_bit(input logic b);
        spiCk = 1'b0;
        spiDi = b;
        repeat (4) @(negedge clock);
        spiCk = 1'b1;
        rise_cyc = cycle_cnt;
        repeat (4) @(negedge clock);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic frame_begin();
        spiS2 = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic frame_end();
        spiCk = 1'b0;
        repeat (4) @(negedge clock);
        spiS2 = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic send_frame();
        frame_begin();
        foreach (tx_q[i]) spi_byte(tx_q[i]);
        frame_end();
        model_frame();
    endtask

    initial begin
        logic [7:0] rb;
        resetN = 1'b0; spiCk = 1'b0; spiS2 = 1'b1; spiDi = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        model_reset();
        check_state("reset");
        @(negedge clock);
        resetN = 1'b1;
        repeat (5) @(negedge clock);

        // Index then start
        tx_q = '{8'h55, 8'h03}; send_frame();
        tx_q = '{8'h53, 8'hFF}; send_frame();
        check_state("idx_start");

        // Three-byte data frame
        tx_q = '{8'h54, 8'hA5, 8'h5A, 8'h01}; send_frame();
        check_writes("data3");
        check_state("data3");

        // Partial byte aborted by select release, then one full byte
        frame_begin();
        spi_byte(8'h54);
        rb = 8'($urandom);
        for (int i = 7; i >= 3; i--) spi_bit(rb[i]);
        frame_end();
        tx_q = '{8'h54, 8'h77}; send_frame();
        check_writes("partial");
        check_state("partial");

        // Random data frames
        for (int f = 0; f < 3; f++) begin
            tx_q = '{8'h54};
            repeat ($urandom_range(1, 4)) tx_q.push_back(8'($urandom));
            send_frame();
            check_writes($sformatf("rand%0d", f));
            check_state($sformatf("rand%0d", f));
        end

        // Restart while downloading, then 17 bytes across the address wrap
        tx_q = '{8'h53, 8'hFF}; send_frame();
        check_state("restart");
        tx_q = '{8'h54};
        repeat (17) tx_q.push_back(8'($urandom));
        send_frame();
        check_writes("wrap");
        check_state("wrap");

        // Index change refused during a download; unknown command ignored
        tx_q = '{8'h55, 8'h07}; send_frame();
        check_state("idx_locked");
        tx_q = '{8'h12, 8'h54, 8'hFF}; send_frame();
        check_writes("unknown");
        check_state("unknown");

        // End download; data afterwards is discarded
        tx_q = '{8'h53, 8'h00}; send_frame();
        check_state("end");
        tx_q = '{8'h54, 8'h3C, 8'hC3}; send_frame();
        check_writes("after_end");
        check_state("after_end");

        // Reset in the middle of a data frame
        tx_q = '{8'h53, 8'hFF}; send_frame();
        tx_q = '{8'h54, 8'($urandom)};
        frame_begin();
        foreach (tx_q[i]) spi_byte(tx_q[i]);
        repeat (6) @(negedge clock);
        model_frame();
        check_writes("pre_reset");
        resetN = 1'b0;
        #1;
        model_reset();
        check_state("mid_reset");
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        spi_byte(8'($urandom));
        spi_byte(8'($urandom));
        frame_end();
        check_writes("post_reset");
        check_state("post_reset");
        tx_q = '{8'h55, 8'h09}; send_frame();
        check_state("idx_after_reset");

        chk("pulse_width", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
